spike_winner_select: RTL and testbench
======================================

Name: spike_winner_select

Overview:
- Downstream classifier stage for the per-neuron spike counters of the output layer.
- At the end of an inference window, snapshots all spike counts and scans them sequentially, one neuron per clock.
- Reports the winning neuron index (maximum count), its count, and tie and no-spike flags.
- Issues a one-cycle counter-clear pulse so the next window starts from zero.

Parameters:
- NUM_INPUTS, 10, number of counters/neurons compared; must be >= 2.
- COUNTER_SIZE, 4, width of each spike count.
- IDX_W, $clog2(NUM_INPUTS), width of the winner index. Derived localparam; not overridable.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- counts_in  input  [COUNTER_SIZE-1:0] x [NUM_INPUTS-1:0] (unpacked array)  spike counts, index i = neuron i
- start  input  1  window-end request; sampled only in IDLE
- busy  output  1  high while the snapshot/scan is in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- winner_idx  output  IDX_W  index of the maximum count
- winner_count  output  COUNTER_SIZE  the maximum count value
- tie  output  1  another index equals the maximum
- no_spike  output  1  every count is zero
- clear_counts  output  1  one-cycle pulse to the counter bank reset, coincident with done

Behaviour:
- Reset (rst=1 at a clk edge):
  - state returns to IDLE;
  - busy, done, clear_counts, winner_idx, winner_count, tie and no_spike all go to 0;
  - snapshot is cleared;
  - reset mid-scan abandons the scan with no done and no clear_counts.
- Inputs: counts_in is driven from spike-clocked logic. The system guarantees counts are stable for at least 2 clk cycles before start and until done. The block captures them only at start and needs no synchronizer.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: start=1 at an edge -> snapshot <= counts_in; scan_idx <= 0; best_idx <= 0; best_cnt <= 0; tie_r <= 0; go to SCAN.
  - SCAN: one compare per cycle at scan_idx.
    - If snap[scan_idx] > best_cnt: best_idx <= scan_idx, best_cnt <= snap, tie_r <= 0.
    - Else if snap[scan_idx] == best_cnt and scan_idx != 0: tie_r <= 1.
    - At scan_idx == NUM_INPUTS-1: go to DONE. Otherwise increment.
  - DONE: register the outputs; assert done and clear_counts for exactly this cycle; go to IDLE.
- busy: 1 in SCAN and DONE, 0 in IDLE.
- Latency: start sampled at edge of cycle T -> SCAN occupies cycles T+1..T+NUM_INPUTS -> done in cycle T+NUM_INPUTS+1. Next start is accepted from cycle T+NUM_INPUTS+2.
- start while busy: ignored, not queued.
- Ties: the lowest index wins; tie=1.
- All-zero counts: winner_idx=0, winner_count=0, no_spike=1. tie is forced to 0 when no_spike=1.
- Saturated counts (all ones) compare normally; comparisons are unsigned.
- Outputs winner_idx, winner_count, tie and no_spike hold their values until the next DONE or reset.

Optional Feature:
- Macro: SPIKE_WINNER_MARGIN_EN.
- Defined:
  - adds output margin [COUNTER_SIZE-1:0] = winner_count minus the second-highest count;
  - a second-best register is tracked during SCAN;
  - a tie gives margin=0; all-zero gives margin=0;
  - margin is updated in DONE, reset to 0, and held like the other results.
- Undefined: no margin port and no second-best logic; everything else is identical.

Decomposition:
- Package snn_pkg:
  - typedef enum logic [1:0] {WS_IDLE, WS_SCAN, WS_DONE} winner_state_t;
  - function clog2_min1, so that IDX_W is at least 1.
- Optional sub-module max_compare_step: a combinational compare/update of best_idx/best_cnt/tie for one element, reused by the margin logic.

Test Plan (NUM_INPUTS=4, COUNTER_SIZE=4):
- counts {3,9,5,1} (idx0..3), start pulse -> done 5 cycles later; winner_idx=1, winner_count=9, tie=0, no_spike=0, clear_counts pulse coincident with done.
- counts {7,2,7,7} -> winner_idx=0, winner_count=7, tie=1; with SPIKE_WINNER_MARGIN_EN, margin=0.
- counts all 0 -> winner_idx=0, winner_count=0, no_spike=1, tie=0.
- counts {15,15,14,0} at saturation -> winner_idx=0, tie=1. Then counts {1,2,3,15}, start -> winner_idx=3, winner_count=15, tie=0; with the macro, margin=12.
- start re-pulsed on cycles T+2 and T+4 during a scan -> exactly one done at T+5; results are those of the first snapshot.
- rst asserted at cycle T+3 mid-scan -> all outputs 0 next cycle, no done/clear_counts. A new start after reset -> correct result.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spike winner-select classifier.
// Optional margin output is enabled with SPIKE_WINNER_MARGIN_EN.
package snn_pkg;

  typedef enum logic [1:0] {WS_IDLE, WS_SCAN, WS_DONE} winner_state_t;

  // Index width must stay at least one bit even for tiny neuron counts.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/max_compare_step.sv
// One element of the running-maximum scan: updates best index/count and tie flag.
// With SPIKE_WINNER_MARGIN_EN the runner-up count is tracked as well.
module max_compare_step #(
  parameter int COUNTER_SIZE = 4,
  parameter int IDX_W        = 4
) (
  input  logic [IDX_W-1:0]        cur_idx,
  input  logic [COUNTER_SIZE-1:0] cur_val,
  input  logic [IDX_W-1:0]        best_idx_in,
  input  logic [COUNTER_SIZE-1:0] best_cnt_in,
  input  logic                    tie_in,
`ifdef SPIKE_WINNER_MARGIN_EN
  input  logic [COUNTER_SIZE-1:0] second_in,
  output logic [COUNTER_SIZE-1:0] second_out,
`endif
  output logic [IDX_W-1:0]        best_idx_out,
  output logic [COUNTER_SIZE-1:0] best_cnt_out,
  output logic                    tie_out
);

  always_comb begin
    best_idx_out = best_idx_in;
    best_cnt_out = best_cnt_in;
    tie_out      = tie_in;
`ifdef SPIKE_WINNER_MARGIN_EN
    second_out   = second_in;
`endif
    if (cur_val > best_cnt_in) begin
      best_idx_out = cur_idx;
      best_cnt_out = cur_val;
      tie_out      = 1'b0;
`ifdef SPIKE_WINNER_MARGIN_EN
      second_out   = best_cnt_in;
`endif
    end else if (cur_val == best_cnt_in && cur_idx != '0) begin
      // Lowest index keeps the win; an equal runner-up means zero margin.
      tie_out      = 1'b1;
`ifdef SPIKE_WINNER_MARGIN_EN
      second_out   = cur_val;
`endif
    end
`ifdef SPIKE_WINNER_MARGIN_EN
    else if (cur_val > second_in) begin
      second_out   = cur_val;
    end
`endif
  end

endmodule

// File: rtl/spike_winner_select.sv
// Snapshots output-layer spike counts on start, scans one neuron per clock and
// reports the arg-max. Define SPIKE_WINNER_MARGIN_EN to add the margin output.
module spike_winner_select
  import snn_pkg::*;
#(
  parameter  int NUM_INPUTS   = 10,
  parameter  int COUNTER_SIZE = 4,
  localparam int IDX_W        = clog2_min1(NUM_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [COUNTER_SIZE-1:0] counts_in [NUM_INPUTS],
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        winner_idx,
  output logic [COUNTER_SIZE-1:0] winner_count,
  output logic                    tie,
  output logic                    no_spike,
`ifdef SPIKE_WINNER_MARGIN_EN
  output logic [COUNTER_SIZE-1:0] margin,
`endif
  output logic                    clear_counts
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  winner_state_t           state_q, state_d;
  logic [COUNTER_SIZE-1:0] snap_q [NUM_INPUTS];
  logic [COUNTER_SIZE-1:0] snap_d [NUM_INPUTS];
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [IDX_W-1:0]        best_idx_q, best_idx_d;
  logic [COUNTER_SIZE-1:0] best_cnt_q, best_cnt_d;
  logic                    tie_r_q, tie_r_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    clear_q, clear_d;
  logic [IDX_W-1:0]        winner_idx_q, winner_idx_d;
  logic [COUNTER_SIZE-1:0] winner_count_q, winner_count_d;
  logic                    tie_q, tie_d;
  logic                    no_spike_q, no_spike_d;

  logic [IDX_W-1:0]        step_idx;
  logic [COUNTER_SIZE-1:0] step_cnt;
  logic                    step_tie;
`ifdef SPIKE_WINNER_MARGIN_EN
  logic [COUNTER_SIZE-1:0] second_q, second_d, step_second;
  logic [COUNTER_SIZE-1:0] margin_q, margin_d;
`endif

  max_compare_step #(
    .COUNTER_SIZE (COUNTER_SIZE),
    .IDX_W        (IDX_W)
  ) u_step (
    .cur_idx      (scan_idx_q),
    .cur_val      (snap_q[scan_idx_q]),
    .best_idx_in  (best_idx_q),
    .best_cnt_in  (best_cnt_q),
    .tie_in       (tie_r_q),
`ifdef SPIKE_WINNER_MARGIN_EN
    .second_in    (second_q),
    .second_out   (step_second),
`endif
    .best_idx_out (step_idx),
    .best_cnt_out (step_cnt),
    .tie_out      (step_tie)
  );

  always_comb begin
    state_d        = state_q;
    snap_d         = snap_q;
    scan_idx_d     = scan_idx_q;
    best_idx_d     = best_idx_q;
    best_cnt_d     = best_cnt_q;
    tie_r_d        = tie_r_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    clear_d        = 1'b0;
    winner_idx_d   = winner_idx_q;
    winner_count_d = winner_count_q;
    tie_d          = tie_q;
    no_spike_d     = no_spike_q;
`ifdef SPIKE_WINNER_MARGIN_EN
    second_d       = second_q;
    margin_d       = margin_q;
`endif
    case (state_q)
      WS_IDLE: begin
        if (start) begin
          snap_d     = counts_in;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          tie_r_d    = 1'b0;
`ifdef SPIKE_WINNER_MARGIN_EN
          second_d   = '0;
`endif
          busy_d     = 1'b1;
          state_d    = WS_SCAN;
        end
      end
      WS_SCAN: begin
        best_idx_d = step_idx;
        best_cnt_d = step_cnt;
        tie_r_d    = step_tie;
`ifdef SPIKE_WINNER_MARGIN_EN
        second_d   = step_second;
`endif
        if (scan_idx_q == LAST_IDX) begin
          // Results land together with done so they are valid in the DONE cycle.
          state_d        = WS_DONE;
          done_d         = 1'b1;
          clear_d        = 1'b1;
          winner_idx_d   = step_idx;
          winner_count_d = step_cnt;
          no_spike_d     = (step_cnt == '0);
          tie_d          = step_tie && (step_cnt != '0);
`ifdef SPIKE_WINNER_MARGIN_EN
          margin_d       = (step_tie || step_cnt == '0) ? '0 : step_cnt - step_second;
`endif
        end else begin
          scan_idx_d = scan_idx_q + IDX_W'(1);
        end
      end
      WS_DONE: begin
        busy_d  = 1'b0;
        state_d = WS_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = WS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WS_IDLE;
      for (int i = 0; i < NUM_INPUTS; i++) snap_q[i] <= '0;
      scan_idx_q     <= '0;
      best_idx_q     <= '0;
      best_cnt_q     <= '0;
      tie_r_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      clear_q        <= 1'b0;
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      tie_q          <= 1'b0;
      no_spike_q     <= 1'b0;
`ifdef SPIKE_WINNER_MARGIN_EN
      second_q       <= '0;
      margin_q       <= '0;
`endif
    end else begin
      state_q        <= state_d;
      snap_q         <= snap_d;
      scan_idx_q     <= scan_idx_d;
      best_idx_q     <= best_idx_d;
      best_cnt_q     <= best_cnt_d;
      tie_r_q        <= tie_r_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      clear_q        <= clear_d;
      winner_idx_q   <= winner_idx_d;
      winner_count_q <= winner_count_d;
      tie_q          <= tie_d;
      no_spike_q     <= no_spike_d;
`ifdef SPIKE_WINNER_MARGIN_EN
      second_q       <= second_d;
      margin_q       <= margin_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign clear_counts = clear_q;
  assign winner_idx   = winner_idx_q;
  assign winner_count = winner_count_q;
  assign tie          = tie_q;
  assign no_spike     = no_spike_q;
`ifdef SPIKE_WINNER_MARGIN_EN
  assign margin       = margin_q;
`endif

endmodule

// File: tb/tb_spike_winner_select.sv
// Scoreboard bench for spike_winner_select (NUM_INPUTS=4, COUNTER_SIZE=4).
// Margin checks are compiled in when SPIKE_WINNER_MARGIN_EN is defined.
module tb_spike_winner_select;

  localparam int N  = 4;
  localparam int CS = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [CS-1:0] counts_in [N];
  logic          start;
  logic          busy, done, tie, no_spike, clear_counts;
  logic [IW-1:0] winner_idx;
  logic [CS-1:0] winner_count;
`ifdef SPIKE_WINNER_MARGIN_EN
  logic [CS-1:0] margin;
`endif

  spike_winner_select #(.NUM_INPUTS(N), .COUNTER_SIZE(CS)) dut (
    .clk          (clk),
    .rst          (rst),
    .counts_in    (counts_in),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .winner_idx   (winner_idx),
    .winner_count (winner_count),
    .tie          (tie),
    .no_spike     (no_spike),
`ifdef SPIKE_WINNER_MARGIN_EN
    .margin       (margin),
`endif
    .clear_counts (clear_counts)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
    bit tie;
    bit nos;
    int mrg;
    int done_cyc;
  } exp_t;

  exp_t exp_q [$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc++;

  function automatic void check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: arg-max with lowest-index preference, plus the runner-up value.
  function automatic exp_t model(input logic [4*N-1:0] v);
    exp_t e;
    int   c [N];
    int   mx, n_eq, sec;
    for (int i = 0; i < N; i++) c[i] = int'(v[4*i +: 4]);
    mx = 0;
    foreach (c[i]) if (c[i] > mx) mx = c[i];
    e.idx = -1;
    n_eq  = 0;
    foreach (c[i]) if (c[i] == mx) begin
      n_eq++;
      if (e.idx < 0) e.idx = i;
    end
    sec = 0;
    foreach (c[i]) if (i != e.idx && c[i] > sec) sec = c[i];
    e.cnt = mx;
    e.nos = (mx == 0);
    e.tie = (n_eq > 1) && (mx != 0);
    e.mrg = mx - sec;
    e.done_cyc = 0;
    return e;
  endfunction

  // Monitor: pops one expectation per done pulse, flags missing/extra pulses.
  always @(negedge clk) begin
    check("clear_eq_done", int'(clear_counts), int'(done));
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_cycle", cyc, e.done_cyc);
        check("winner_idx", int'(winner_idx), e.idx);
        check("winner_count", int'(winner_count), e.cnt);
        check("tie", int'(tie), int'(e.tie));
        check("no_spike", int'(no_spike), int'(e.nos));
        check("busy_in_done", int'(busy), 1);
`ifdef SPIKE_WINNER_MARGIN_EN
        check("margin", int'(margin), e.mrg);
`endif
      end
    end else if (exp_q.size() != 0 && cyc > exp_q[0].done_cyc) begin
      check("missing_done", 0, 1);
      void'(exp_q.pop_front());
    end
  end

  task automatic set_counts(input logic [4*N-1:0] v);
    for (int i = 0; i < N; i++) counts_in[i] = v[4*i +: 4];
  endtask

  // Presents counts, lets them settle two cycles, pulses start, queues expectation.
  task automatic launch(input logic [4*N-1:0] v);
    exp_t e;
    set_counts(v);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    e = model(v);
    e.done_cyc = cyc + N + 1;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_clear"}, int'(clear_counts), 0);
    check({tag, "_idx"}, int'(winner_idx), 0);
    check({tag, "_cnt"}, int'(winner_count), 0);
    check({tag, "_tie"}, int'(tie), 0);
    check({tag, "_nos"}, int'(no_spike), 0);
`ifdef SPIKE_WINNER_MARGIN_EN
    check({tag, "_margin"}, int'(margin), 0);
`endif
  endtask

  // counts packed idx3..idx0 from MSB to LSB nibble
  function automatic logic [4*N-1:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {4'(c3), 4'(c2), 4'(c1), 4'(c0)};
  endfunction

  initial begin
    logic [4*N-1:0] v;
    rst   = 1'b1;
    start = 1'b0;
    set_counts('0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    launch(pk(3, 9, 5, 1));
    @(negedge clk);
    check("busy_scan", int'(busy), 1);
    drain();
    launch(pk(7, 2, 7, 7));   drain();
    launch(pk(0, 0, 0, 0));   drain();
    launch(pk(15, 15, 14, 0)); drain();
    launch(pk(1, 2, 3, 15));  drain();
    launch(pk(0, 0, 0, 4));   drain();
    check("hold_idx", int'(winner_idx), 3);
    check("idle_busy", int'(busy), 0);

    // Re-pulsed start while busy, with counts changed after the snapshot.
    launch(pk(2, 8, 8, 1));
    set_counts(pk(9, 0, 0, 0));
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    drain();

    // Reset in the middle of a scan abandons it.
    launch(pk(5, 6, 7, 8));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    repeat (6) @(negedge clk) check("no_done_after_rst", int'(done), 0);
    launch(pk(4, 11, 2, 11)); drain();

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++)
        v[4*i +: 4] = (t % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      launch(v);
      drain();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
